cache_ctrl: RTL and testbench
=============================

Name: cache_ctrl

Overview:
Sequencing controller for the 16-entry direct-mapped cache array. Sits between one CPU-side requester and the backing memory, and drives the array's write-enable, address and write-data inputs. Adds per-line valid bits, which the array lacks, and applies a write-through, write-update policy. Fills lines on read misses, flushes on command, and keeps hit/miss statistics.

Parameters:
IDX_W, 4, index width; the cache has 2**IDX_W lines, and addr[IDX_W-1:0] is the index.
TAG_W, 4, tag width; the tag is the upper address bits.
DATA_W, 8, data width.
MEM_TIMEOUT, 255, maximum cycles to wait for mem_ack before aborting (range 1..255).
CNT_W, 16, width of the statistics counters.

Ports:
clk  in  1  clock, rising edge.
rst_n  in  1  asynchronous active-low reset.
cpu_req  in  1  request strobe; sampled only in IDLE.
cpu_we  in  1  1 = write, 0 = read.
cpu_addr  in  IDX_W+TAG_W  request address.
cpu_wdata  in  DATA_W  write data.
cpu_ready  out  1  one-cycle completion pulse.
cpu_rdata  out  DATA_W  read data; valid while cpu_ready=1.
cpu_hit  out  1  1 = the request hit the cache; valid while cpu_ready=1.
cpu_err  out  1  1 = memory timeout; valid while cpu_ready=1.
busy  out  1  1 whenever state != IDLE.
flush  in  1  invalidate all lines; sampled only in IDLE.
cache_we  out  1  array write enable.
cache_addr  out  IDX_W+TAG_W  array address; always equals the latched request address.
cache_wdata  out  DATA_W  array write data.
cache_rdata  in  DATA_W  array read data (combinational).
cache_hit  in  1  array tag compare result (combinational).
mem_req  out  1  memory request; held until mem_ack.
mem_we  out  1  memory write.
mem_addr  out  IDX_W+TAG_W  memory address.
mem_wdata  out  DATA_W  memory write data.
mem_rdata  in  DATA_W  memory read data; valid with mem_ack.
mem_ack  in  1  one-cycle memory acknowledge.
hit_count  out  CNT_W  saturating count of hits.
miss_count  out  CNT_W  saturating count of misses.

Behaviour:
- Reset (rst_n=0, asynchronous):
  - state goes to IDLE and all valid bits clear.
  - All outputs are 0, including the counters and the latched address/data.
  - Reset mid-operation abandons any memory transaction; mem_req drops immediately.
- States: IDLE, LOOKUP, MEM_RD, FILL, MEM_WR, RESP.
- IDLE:
  - flush=1 clears all valid bits at the clock edge and stays in IDLE. flush has priority over cpu_req; the request is ignored that cycle.
  - Otherwise, cpu_req=1 latches cpu_addr, cpu_we and cpu_wdata, then moves to LOOKUP.
  - cpu_req while busy=1 is ignored. The requester must wait for cpu_ready.
- LOOKUP: effective hit = cache_hit AND valid[idx].
  - Read hit: latch cpu_rdata=cache_rdata and hit=1; increment hit_count; go to RESP.
  - Read miss: increment miss_count; go to MEM_RD.
  - Write: cache_we=1 and cache_wdata=latched wdata this cycle; set valid[idx]; go to MEM_WR. The write hit/miss is counted in the statistics and reported on cpu_hit.
- MEM_RD: mem_req=1, mem_we=0, mem_addr=latched address.
  - On mem_ack: latch mem_rdata and go to FILL.
- FILL: cache_we=1 and cache_wdata=the latched fill data; set valid[idx]; cpu_rdata=fill data; go to RESP.
- MEM_WR: mem_req=1, mem_we=1, mem_wdata=latched wdata.
  - On mem_ack: go to RESP.
- Memory handshake rules:
  - mem_req, mem_we, mem_addr and mem_wdata stay stable until the ack cycle.
  - mem_req drops in the cycle after mem_ack.
  - mem_ack in any state other than MEM_RD or MEM_WR is ignored.
- Timeout:
  - An 8-bit wait counter clears on entry to MEM_RD or MEM_WR and increments each cycle without an ack.
  - When it reaches MEM_TIMEOUT without an ack: go to RESP with cpu_err=1.
  - A read timeout performs no fill and leaves cpu_rdata=0.
  - A write timeout leaves the cache line already updated.
  - mem_ack arriving in the same cycle the count reaches MEM_TIMEOUT wins: the ack is taken and there is no error.
- RESP: cpu_ready=1 for exactly one cycle, then go to IDLE. cpu_rdata, cpu_hit and cpu_err hold until the next request is latched.
- Latency, counted from the cpu_req sample edge to the cpu_ready cycle:
  - Read hit: 2 cycles.
  - Read miss: 4 + (cycles from mem_req to mem_ack).
  - Write: 3 + (cycles from mem_req to mem_ack).
- Counters saturate at 2**CNT_W-1 and never wrap.
- cache_we is asserted only in LOOKUP (write) or FILL, never in IDLE.

Test Plan:
- After reset, read addr 0x35 with memory returning 0xA7 and ack after 3 cycles → mem_req with mem_addr=0x35; cpu_ready with cpu_rdata=0xA7, cpu_hit=0; miss_count=1.
- Read 0x35 again → cpu_ready 2 cycles after the request, cpu_rdata=0xA7, cpu_hit=1, no mem_req; hit_count=1.
- Write 0xC5 with data 0x5E → cache_we in LOOKUP; mem_we=1, mem_wdata=0x5E; cpu_hit=0. Read 0xC5 → hit with 0x5E. Read 0x35 → miss, because both addresses share index 5.
- flush in IDLE with cpu_req asserted in the same cycle → the request is ignored; a following read of 0xC5 misses, and a memory fetch occurs despite the matching tag.
- Read miss on 0x10 with mem_ack never arriving, MEM_TIMEOUT=8 → cpu_ready 8 cycles after mem_req rises, with cpu_err=1 and cpu_rdata=0x00. A later read of 0x10 still misses.
- Assert rst_n low during MEM_RD → mem_req goes low asynchronously, busy=0, counters=0. A subsequent read of 0x35 misses.

Source files
------------

// File: rtl/cache_ctrl_if.sv
// Bus bundle around cache_ctrl: CPU requester side, cache array side, backing memory side
// and the statistics outputs. The controller uses the slave modport, its surroundings the master.
interface cache_ctrl_if #(
    parameter int unsigned IDX_W  = 4,
    parameter int unsigned TAG_W  = 4,
    parameter int unsigned DATA_W = 8,
    parameter int unsigned CNT_W  = 16
);
    localparam int unsigned AW = IDX_W + TAG_W;

    logic              cpu_req;
    logic              cpu_we;
    logic [AW-1:0]     cpu_addr;
    logic [DATA_W-1:0] cpu_wdata;
    logic              cpu_ready;
    logic [DATA_W-1:0] cpu_rdata;
    logic              cpu_hit;
    logic              cpu_err;
    logic              busy;
    logic              flush;

    logic              cache_we;
    logic [AW-1:0]     cache_addr;
    logic [DATA_W-1:0] cache_wdata;
    logic [DATA_W-1:0] cache_rdata;
    logic              cache_hit;

    logic              mem_req;
    logic              mem_we;
    logic [AW-1:0]     mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;
    logic              mem_ack;

    logic [CNT_W-1:0]  hit_count;
    logic [CNT_W-1:0]  miss_count;

    modport slave (
        input  cpu_req, cpu_we, cpu_addr, cpu_wdata, flush,
        output cpu_ready, cpu_rdata, cpu_hit, cpu_err, busy,
        output cache_we, cache_addr, cache_wdata,
        input  cache_rdata, cache_hit,
        output mem_req, mem_we, mem_addr, mem_wdata,
        input  mem_rdata, mem_ack,
        output hit_count, miss_count
    );

    modport master (
        output cpu_req, cpu_we, cpu_addr, cpu_wdata, flush,
        input  cpu_ready, cpu_rdata, cpu_hit, cpu_err, busy,
        input  cache_we, cache_addr, cache_wdata,
        output cache_rdata, cache_hit,
        input  mem_req, mem_we, mem_addr, mem_wdata,
        output mem_rdata, mem_ack,
        input  hit_count, miss_count
    );
endinterface

// File: rtl/cache_ctrl.sv
// Sequencing controller for a direct-mapped cache array: valid bits, write-through/write-update,
// read-miss fill, flush, memory timeout and saturating hit/miss statistics.
module cache_ctrl #(
    parameter int unsigned IDX_W       = 4,
    parameter int unsigned TAG_W       = 4,
    parameter int unsigned DATA_W      = 8,
    parameter int unsigned MEM_TIMEOUT = 255,
    parameter int unsigned CNT_W       = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    cache_ctrl_if.slave bus
);
    localparam int unsigned AW    = IDX_W + TAG_W;
    localparam int unsigned LINES = 2 ** IDX_W;
    localparam logic [7:0]  WAIT_LAST = 8'(MEM_TIMEOUT - 1);
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    typedef enum logic [2:0] {
        StIdle,
        StLookup,
        StMemRd,
        StFill,
        StMemWr,
        StResp
    } state_e;

    state_e            state_q, state_d;
    logic [AW-1:0]     addr_q, addr_d;
    logic              we_q, we_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [DATA_W-1:0] fill_q, fill_d;
    logic [DATA_W-1:0] rdata_q, rdata_d;
    logic              hit_q, hit_d;
    logic              err_q, err_d;
    logic [LINES-1:0]  valid_q, valid_d;
    logic [7:0]        wait_q, wait_d;
    logic [CNT_W-1:0]  hit_cnt_q, hit_cnt_d;
    logic [CNT_W-1:0]  miss_cnt_q, miss_cnt_d;

    logic              cache_we;
    logic [DATA_W-1:0] cache_wdata;
    logic              mem_req;
    logic              mem_we;
    logic [IDX_W-1:0]  idx;
    logic              eff_hit;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == CNT_MAX) ? v : v + {{(CNT_W-1){1'b0}}, 1'b1};
    endfunction

    assign idx = addr_q[IDX_W-1:0];
    // The array compares tags only; a line counts as present only while its valid bit is set.
    assign eff_hit = bus.cache_hit & valid_q[idx];

    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        we_d        = we_q;
        wdata_d     = wdata_q;
        fill_d      = fill_q;
        rdata_d     = rdata_q;
        hit_d       = hit_q;
        err_d       = err_q;
        valid_d     = valid_q;
        wait_d      = wait_q;
        hit_cnt_d   = hit_cnt_q;
        miss_cnt_d  = miss_cnt_q;
        cache_we    = 1'b0;
        cache_wdata = wdata_q;
        mem_req     = 1'b0;
        mem_we      = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (bus.flush) begin
                    valid_d = '0;
                end else if (bus.cpu_req) begin
                    addr_d  = bus.cpu_addr;
                    we_d    = bus.cpu_we;
                    wdata_d = bus.cpu_wdata;
                    rdata_d = '0;
                    hit_d   = 1'b0;
                    err_d   = 1'b0;
                    state_d = StLookup;
                end
            end
            StLookup: begin
                hit_d = eff_hit;
                if (eff_hit) begin
                    hit_cnt_d = sat_inc(hit_cnt_q);
                end else begin
                    miss_cnt_d = sat_inc(miss_cnt_q);
                end
                if (we_q) begin
                    // Write-update: the line is written regardless of hit, then written through.
                    cache_we     = 1'b1;
                    valid_d[idx] = 1'b1;
                    wait_d       = '0;
                    state_d      = StMemWr;
                end else if (eff_hit) begin
                    rdata_d = bus.cache_rdata;
                    state_d = StResp;
                end else begin
                    wait_d  = '0;
                    state_d = StMemRd;
                end
            end
            StMemRd: begin
                mem_req = 1'b1;
                if (bus.mem_ack) begin
                    fill_d  = bus.mem_rdata;
                    state_d = StFill;
                end else if (wait_q == WAIT_LAST) begin
                    err_d   = 1'b1;
                    state_d = StResp;
                end else begin
                    wait_d = wait_q + 8'd1;
                end
            end
            StFill: begin
                cache_we     = 1'b1;
                cache_wdata  = fill_q;
                valid_d[idx] = 1'b1;
                rdata_d      = fill_q;
                state_d      = StResp;
            end
            StMemWr: begin
                mem_req = 1'b1;
                mem_we  = 1'b1;
                if (bus.mem_ack) begin
                    state_d = StResp;
                end else if (wait_q == WAIT_LAST) begin
                    err_d   = 1'b1;
                    state_d = StResp;
                end else begin
                    wait_d = wait_q + 8'd1;
                end
            end
            StResp: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            addr_q     <= '0;
            we_q       <= 1'b0;
            wdata_q    <= '0;
            fill_q     <= '0;
            rdata_q    <= '0;
            hit_q      <= 1'b0;
            err_q      <= 1'b0;
            valid_q    <= '0;
            wait_q     <= '0;
            hit_cnt_q  <= '0;
            miss_cnt_q <= '0;
        end else begin
            addr_q     <= addr_d;
            we_q       <= we_d;
            wdata_q    <= wdata_d;
            fill_q     <= fill_d;
            rdata_q    <= rdata_d;
            hit_q      <= hit_d;
            err_q      <= err_d;
            valid_q    <= valid_d;
            wait_q     <= wait_d;
            hit_cnt_q  <= hit_cnt_d;
            miss_cnt_q <= miss_cnt_d;
        end
    end

    assign bus.cpu_ready   = (state_q == StResp);
    assign bus.cpu_rdata   = rdata_q;
    assign bus.cpu_hit     = hit_q;
    assign bus.cpu_err     = err_q;
    assign bus.busy        = (state_q != StIdle);
    assign bus.cache_we    = cache_we;
    assign bus.cache_addr  = addr_q;
    assign bus.cache_wdata = cache_wdata;
    assign bus.mem_req     = mem_req;
    assign bus.mem_we      = mem_we;
    assign bus.mem_addr    = addr_q;
    assign bus.mem_wdata   = wdata_q;
    assign bus.hit_count   = hit_cnt_q;
    assign bus.miss_count  = miss_cnt_q;
endmodule

// File: tb/tb_cache_ctrl.sv
// Bench for cache_ctrl: array and memory models around the DUT, checked against a
// transaction-level reference of the cache contents, latency and statistics.
module tb_cache_ctrl;
    localparam int unsigned IDX_W       = 4;
    localparam int unsigned TAG_W       = 4;
    localparam int unsigned DATA_W      = 8;
    localparam int unsigned CNT_W       = 16;
    localparam int          MEM_TIMEOUT = 8;

    logic clk   = 1'b0;
    logic rst_n = 1'b1;
    always #5 clk = ~clk;

    cache_ctrl_if #(.IDX_W(IDX_W), .TAG_W(TAG_W), .DATA_W(DATA_W), .CNT_W(CNT_W)) bus ();

    cache_ctrl #(
        .IDX_W      (IDX_W),
        .TAG_W      (TAG_W),
        .DATA_W     (DATA_W),
        .MEM_TIMEOUT(MEM_TIMEOUT),
        .CNT_W      (CNT_W)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    // Environment: tag/data array (no valid bits) and backing memory.
    logic [3:0] arr_tag  [16];
    logic [7:0] arr_data [16];
    logic [7:0] mem_arr  [256];

    assign bus.cache_hit   = (arr_tag[bus.cache_addr[3:0]] == bus.cache_addr[7:4]);
    assign bus.cache_rdata = arr_data[bus.cache_addr[3:0]];

    // Reference: what the cache should hold, what memory should hold, and the statistics.
    bit          rm_valid [16];
    logic [3:0]  rm_tag   [16];
    logic [7:0]  rm_data  [16];
    logic [7:0]  ref_mem  [256];
    int unsigned rm_hits;
    int unsigned rm_misses;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic rm_clear_valid();
        for (int i = 0; i < 16; i++) rm_valid[i] = 1'b0;
    endtask

    // delay: cycles from mem_req rising to mem_ack; negative means never acknowledge.
    task automatic do_txn(input logic we, input logic [7:0] addr, input logic [7:0] wdata,
                          input int delay);
        int          idx;
        bit          exp_hit, exp_mem, exp_to;
        int          exp_lat, exp_cwe;
        logic [7:0]  exp_rdata;
        int          cyc, req_start, lat, mem_bad, cwe_cnt;
        bit          done, mem_seen, acked, pend;
        logic [3:0]  pidx, ptag;
        logic [7:0]  pdata, got_rdata;
        logic        got_hit, got_err;

        idx       = int'(addr[3:0]);
        exp_hit   = rm_valid[idx] && (rm_tag[idx] == addr[7:4]);
        exp_mem   = we || !exp_hit;
        exp_to    = exp_mem && (delay < 0 || delay >= MEM_TIMEOUT);
        exp_lat   = !exp_mem ? 2 : exp_to ? 2 + MEM_TIMEOUT : (we ? 3 : 4) + delay;
        exp_rdata = (we || exp_to) ? 8'h00 : exp_hit ? rm_data[idx] : ref_mem[addr];
        exp_cwe   = (we || (!exp_hit && !exp_to)) ? 1 : 0;

        if (exp_hit) rm_hits = (rm_hits == 65535) ? rm_hits : rm_hits + 1;
        else rm_misses = (rm_misses == 65535) ? rm_misses : rm_misses + 1;
        if (we) begin
            rm_valid[idx] = 1'b1;
            rm_tag[idx]   = addr[7:4];
            rm_data[idx]  = wdata;
            if (!exp_to) ref_mem[addr] = wdata;
        end else if (!exp_hit && !exp_to) begin
            rm_valid[idx] = 1'b1;
            rm_tag[idx]   = addr[7:4];
            rm_data[idx]  = ref_mem[addr];
        end

        @(negedge clk);
        bus.cpu_req   = 1'b1;
        bus.cpu_we    = we;
        bus.cpu_addr  = addr;
        bus.cpu_wdata = wdata;
        @(negedge clk);
        bus.cpu_req   = 1'b0;
        bus.cpu_we    = 1'($urandom);
        bus.cpu_addr  = 8'($urandom);
        bus.cpu_wdata = 8'($urandom);

        cyc = 1; req_start = -1; lat = -1; mem_bad = 0; cwe_cnt = 0;
        done = 0; mem_seen = 0; acked = 0; pend = 0;
        got_rdata = '0; got_hit = 1'b0; got_err = 1'b0;
        pidx = '0; ptag = '0; pdata = '0;
        while (!done && cyc < 40) begin
            if (pend) begin
                arr_tag[pidx]  = ptag;
                arr_data[pidx] = pdata;
                pend = 0;
            end
            bus.mem_ack = 1'b0;
            if (bus.cache_we) begin
                cwe_cnt++;
                pend  = 1;
                pidx  = bus.cache_addr[3:0];
                ptag  = bus.cache_addr[7:4];
                pdata = bus.cache_wdata;
                if (bus.cache_addr !== addr || !bus.busy) mem_bad++;
            end
            if (bus.mem_req) begin
                mem_seen = 1;
                if (acked) mem_bad++;
                if (req_start < 0) req_start = cyc;
                if (bus.mem_addr !== addr || bus.mem_we !== we || (we && bus.mem_wdata !== wdata))
                    mem_bad++;
                if (delay >= 0 && cyc - req_start == delay) begin
                    bus.mem_ack = 1'b1;
                    acked = 1;
                    if (we) mem_arr[addr] = bus.mem_wdata;
                    else bus.mem_rdata = mem_arr[addr];
                end
            end
            if (bus.cpu_ready) begin
                done      = 1;
                lat       = cyc;
                got_rdata = bus.cpu_rdata;
                got_hit   = bus.cpu_hit;
                got_err   = bus.cpu_err;
            end
            @(negedge clk);
            cyc++;
        end
        bus.mem_ack = 1'b0;
        if (pend) begin
            arr_tag[pidx]  = ptag;
            arr_data[pidx] = pdata;
        end

        chk("ready_seen", 32'(done), 32'd1);
        chk("latency", 32'(lat), 32'(exp_lat));
        chk("rdata", 32'(got_rdata), 32'(exp_rdata));
        chk("hit", 32'(got_hit), 32'(exp_hit));
        chk("err", 32'(got_err), 32'(exp_to));
        chk("mem_req_seen", 32'(mem_seen), 32'(exp_mem));
        chk("bus_protocol", 32'(mem_bad), 32'd0);
        chk("cache_we_cycles", 32'(cwe_cnt), 32'(exp_cwe));
        if (exp_to) chk("timeout_from_req", 32'(lat - req_start), 32'(MEM_TIMEOUT));
        chk("idle_after_resp", 32'(bus.busy), 32'd0);
        chk("rdata_hold", 32'(bus.cpu_rdata), 32'(exp_rdata));
        chk("hit_count", 32'(bus.hit_count), rm_hits);
        chk("miss_count", 32'(bus.miss_count), rm_misses);
    endtask

    task automatic do_flush();
        @(negedge clk);
        bus.flush = 1'b1;
        @(negedge clk);
        bus.flush = 1'b0;
        rm_clear_valid();
        chk("flush_idle", 32'(bus.busy), 32'd0);
    endtask

    initial begin
        bus.cpu_req = 1'b0; bus.cpu_we = 1'b0; bus.cpu_addr = '0; bus.cpu_wdata = '0;
        bus.flush = 1'b0; bus.mem_ack = 1'b0; bus.mem_rdata = '0;
        for (int i = 0; i < 16; i++) begin
            arr_tag[i]  = 4'($urandom);
            arr_data[i] = 8'($urandom);
        end
        for (int i = 0; i < 256; i++) begin
            mem_arr[i] = 8'($urandom);
            ref_mem[i] = mem_arr[i];
        end
        mem_arr[8'h35] = 8'hA7;
        ref_mem[8'h35] = 8'hA7;
        rm_clear_valid();
        rm_hits = 0;
        rm_misses = 0;

        #1 rst_n = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_cpu_ready", 32'(bus.cpu_ready), 32'd0);
        chk("rst_busy", 32'(bus.busy), 32'd0);
        chk("rst_mem_req", 32'(bus.mem_req), 32'd0);
        chk("rst_cache_we", 32'(bus.cache_we), 32'd0);
        chk("rst_cpu_rdata", 32'(bus.cpu_rdata), 32'd0);
        chk("rst_cache_addr", 32'(bus.cache_addr), 32'd0);
        chk("rst_hit_count", 32'(bus.hit_count), 32'd0);
        chk("rst_miss_count", 32'(bus.miss_count), 32'd0);
        rst_n = 1'b1;

        // Miss with fill, then hit, then write-through into the shared index 5.
        do_txn(1'b0, 8'h35, 8'h00, 3);
        chk("first_fill_value", 32'(bus.cpu_rdata), 32'hA7);
        do_txn(1'b0, 8'h35, 8'h00, 0);
        do_txn(1'b1, 8'hC5, 8'h5E, 1);
        chk("write_through_mem", 32'(mem_arr[8'hC5]), 32'h5E);
        do_txn(1'b0, 8'hC5, 8'h00, 2);
        do_txn(1'b0, 8'h35, 8'h00, 0);
        do_txn(1'b0, 8'hC5, 8'h00, 1);

        // Flush wins over a simultaneous request; the array tag still matches afterwards.
        @(negedge clk);
        bus.flush = 1'b1; bus.cpu_req = 1'b1; bus.cpu_addr = 8'hC5; bus.cpu_we = 1'b0;
        @(negedge clk);
        bus.flush = 1'b0; bus.cpu_req = 1'b0;
        rm_clear_valid();
        chk("flush_req_ignored", 32'(bus.busy), 32'd0);
        do_txn(1'b0, 8'hC5, 8'h00, 2);

        // Stray ack while idle must do nothing.
        @(negedge clk);
        bus.mem_ack = 1'b1;
        @(negedge clk);
        bus.mem_ack = 1'b0;
        chk("stray_ack_idle", 32'(bus.busy), 32'd0);

        // Timeouts and the ack-at-the-limit boundary.
        do_txn(1'b0, 8'h10, 8'h00, -1);
        do_txn(1'b0, 8'h10, 8'h00, MEM_TIMEOUT - 1);
        do_txn(1'b1, 8'h21, 8'h3C, -1);
        do_txn(1'b0, 8'h21, 8'h00, 0);

        // Asynchronous reset in the middle of a memory read.
        @(negedge clk);
        bus.cpu_req = 1'b1; bus.cpu_we = 1'b0; bus.cpu_addr = 8'h35;
        @(negedge clk);
        bus.cpu_req = 1'b0;
        for (int i = 0; i < 10 && !bus.mem_req; i++) @(negedge clk);
        chk("pre_rst_mem_req", 32'(bus.mem_req), 32'd1);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("async_rst_mem_req", 32'(bus.mem_req), 32'd0);
        chk("async_rst_busy", 32'(bus.busy), 32'd0);
        chk("async_rst_hits", 32'(bus.hit_count), 32'd0);
        chk("async_rst_misses", 32'(bus.miss_count), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        rm_clear_valid();
        rm_hits = 0;
        rm_misses = 0;
        do_txn(1'b0, 8'h35, 8'h00, 1);

        // Randomized traffic over a small address set to get a mix of hits and misses.
        for (int t = 0; t < 40; t++) begin
            logic [7:0] a;
            int         d;
            a = {2'b00, 2'($urandom), 2'b00, 2'($urandom)};
            d = ($urandom_range(0, 9) < 2) ? -1 : int'($urandom_range(0, MEM_TIMEOUT));
            if ($urandom_range(0, 9) == 0) do_flush();
            do_txn(($urandom_range(0, 2) == 0), a, 8'($urandom), d);
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule
